// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the memory-access stage: opcodes, access sizes,
// LSU state encoding and small decode helpers.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } lsu_state_e;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

    function automatic logic is_alu_writer(input logic [6:0] op);
        return (op == OP_OP) || (op == OP_IMM) || (op == OP_LUI) || (op == OP_AUIPC) ||
               (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/stage_ma_lsu_if.sv
// Request/acknowledge data-memory port between the MA stage and data memory.
interface stage_ma_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication/byte enables and load extract/extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift_s;

    // Store lanes: replicate the datum across the word, enable only its bytes.
    always_comb begin
        st_wdata = st_data;
        st_be    = 4'b0000;
        case (st_funct3[1:0])
            2'b00: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = 4'b0001 << st_addr_lo;
            end
            2'b01: begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = 4'b0011 << st_addr_lo;
            end
            2'b10: begin
                st_wdata = st_data;
                st_be    = 4'b1111;
            end
            default: begin
                st_wdata = st_data;
                st_be    = 4'b0000;
            end
        endcase
    end

    assign ld_shift_s = ld_rdata >> {ld_addr_lo, 3'b000};

    // Load extract: addressed bytes moved to bit 0, then sign or zero extended.
    always_comb begin
        ld_data = ld_shift_s;
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
            F3_H:    ld_data = {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
            F3_W:    ld_data = ld_shift_s;
            F3_BU:   ld_data = {24'h00_0000, ld_shift_s[7:0]};
            F3_HU:   ld_data = {16'h0000, ld_shift_s[15:0]};
            default: ld_data = ld_shift_s;
        endcase
    end

endmodule

// File: rtl/stage_ma_lsu.sv
// Memory-access stage: drives the data-memory port, stalls EX/MA while an access
// is outstanding and produces one registered write-back record per writer.
module stage_ma_lsu
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           busc_in,
    input  logic [31:0]           busb_in,
    input  logic [31:0]           pc_in,
    input  logic [4:0]            rd_in,
    input  logic [2:0]            funct3_in,
    input  logic [6:0]            op_in,
    output logic                  stall,
    stage_ma_lsu_if.master        mem,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic                  misalign,
    output logic [31:0]           misalign_pc
);

    lsu_state_e  state_r, state_nxt_s;
    logic        ld_r, ld_nxt_s;
    logic [2:0]  ld_f3_r, ld_f3_nxt_s;
    logic [1:0]  ld_lo_r, ld_lo_nxt_s;
    logic [4:0]  ld_rd_r, ld_rd_nxt_s;
    logic        req_r, req_nxt_s;
    logic        we_r, we_nxt_s;
    logic [31:0] addr_r, addr_nxt_s;
    logic [31:0] wdata_r, wdata_nxt_s;
    logic [3:0]  be_r, be_nxt_s;
    logic        wb_valid_r, wb_valid_nxt_s;
    logic [4:0]  wb_rd_r, wb_rd_nxt_s;
    logic [31:0] wb_data_r, wb_data_nxt_s;
    logic        mis_r, mis_nxt_s;
    logic [31:0] mis_pc_r, mis_pc_nxt_s;
    logic        stall_s;

    logic        is_ld_s, is_st_s, mis_s, acc_s, wr_s;
    logic [31:0] st_wdata_s, ld_data_s;
    logic [3:0]  st_be_s;

    assign is_ld_s = (op_in == OP_LOAD) && load_f3_ok(funct3_in);
    assign is_st_s = (op_in == OP_STORE) && store_f3_ok(funct3_in);
    assign mis_s   = (is_ld_s || is_st_s) && is_misaligned(funct3_in, busc_in[1:0]);
    assign acc_s   = (is_ld_s || is_st_s) && !mis_s;
    assign wr_s    = is_alu_writer(op_in);

    lsu_align u_align (
        .st_funct3  (funct3_in),
        .st_addr_lo (busc_in[1:0]),
        .st_data    (busb_in),
        .st_wdata   (st_wdata_s),
        .st_be      (st_be_s),
        .ld_funct3  (ld_f3_r),
        .ld_addr_lo (ld_lo_r),
        .ld_rdata   (mem.mem_rdata),
        .ld_data    (ld_data_s)
    );

    // Next-state, stall and next-output decode.
    always_comb begin
        state_nxt_s    = state_r;
        stall_s        = 1'b0;
        ld_nxt_s       = ld_r;
        ld_f3_nxt_s    = ld_f3_r;
        ld_lo_nxt_s    = ld_lo_r;
        ld_rd_nxt_s    = ld_rd_r;
        req_nxt_s      = req_r;
        we_nxt_s       = we_r;
        addr_nxt_s     = addr_r;
        wdata_nxt_s    = wdata_r;
        be_nxt_s       = be_r;
        wb_valid_nxt_s = 1'b0;
        wb_rd_nxt_s    = wb_rd_r;
        wb_data_nxt_s  = wb_data_r;
        mis_nxt_s      = 1'b0;
        mis_pc_nxt_s   = mis_pc_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_s) begin
                    stall_s     = 1'b1;
                    state_nxt_s = ST_BUSY;
                    req_nxt_s   = 1'b1;
                    we_nxt_s    = is_st_s;
                    addr_nxt_s  = {busc_in[31:2], 2'b00};
                    wdata_nxt_s = st_wdata_s;
                    be_nxt_s    = is_st_s ? st_be_s : 4'b0000;
                    ld_nxt_s    = is_ld_s;
                    ld_f3_nxt_s = funct3_in;
                    ld_lo_nxt_s = busc_in[1:0];
                    ld_rd_nxt_s = rd_in;
                end else if (mis_s) begin
                    mis_nxt_s    = 1'b1;
                    mis_pc_nxt_s = pc_in;
                end else if (wr_s) begin
                    wb_valid_nxt_s = 1'b1;
                    wb_rd_nxt_s    = rd_in;
                    wb_data_nxt_s  = busc_in;
                end else begin
                    stall_s = 1'b0;
                end
            end
            ST_BUSY: begin
                stall_s = !mem.mem_ack;
                if (mem.mem_ack) begin
                    state_nxt_s    = ST_IDLE;
                    req_nxt_s      = 1'b0;
                    wb_valid_nxt_s = ld_r;
                    if (ld_r) begin
                        wb_rd_nxt_s   = ld_rd_r;
                        wb_data_nxt_s = ld_data_s;
                    end else begin
                        wb_rd_nxt_s   = wb_rd_r;
                    end
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                req_nxt_s   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset also drops any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ld_r       <= 1'b0;
            ld_f3_r    <= 3'b000;
            ld_lo_r    <= 2'b00;
            ld_rd_r    <= 5'd0;
            req_r      <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            be_r       <= 4'b0000;
            wb_valid_r <= 1'b0;
            wb_rd_r    <= 5'd0;
            wb_data_r  <= 32'h0000_0000;
            mis_r      <= 1'b0;
            mis_pc_r   <= 32'h0000_0000;
        end else begin
            state_r    <= state_nxt_s;
            ld_r       <= ld_nxt_s;
            ld_f3_r    <= ld_f3_nxt_s;
            ld_lo_r    <= ld_lo_nxt_s;
            ld_rd_r    <= ld_rd_nxt_s;
            req_r      <= req_nxt_s;
            we_r       <= we_nxt_s;
            addr_r     <= addr_nxt_s;
            wdata_r    <= wdata_nxt_s;
            be_r       <= be_nxt_s;
            wb_valid_r <= wb_valid_nxt_s;
            wb_rd_r    <= wb_rd_nxt_s;
            wb_data_r  <= wb_data_nxt_s;
            mis_r      <= mis_nxt_s;
            mis_pc_r   <= mis_pc_nxt_s;
        end
    end

    assign stall         = stall_s && !rst;
    assign mem.mem_req   = req_r;
    assign mem.mem_we    = we_r;
    assign mem.mem_addr  = addr_r;
    assign mem.mem_wdata = wdata_r;
    assign mem.mem_be    = be_r;
    assign wb_valid      = wb_valid_r;
    assign wb_rd         = wb_rd_r;
    assign wb_data       = wb_data_r;
    assign misalign      = mis_r;
    assign misalign_pc   = mis_pc_r;

endmodule

// File: tb/tb_stage_ma_lsu.sv
// Randomized bench for stage_ma_lsu: an EX/MA feeder, a memory responder and a
// transaction-level model of the expected stage behaviour.
module tb_stage_ma_lsu;
    import riscv_pkg::*;

    localparam int NCYC  = 1500;
    localparam int K_NONE = 0, K_WR = 1, K_LD = 2, K_ST = 3, K_MIS = 4;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] busc, busb, pc;
        logic [4:0]  rd;
        int          delay;
        logic [31:0] rdata;
        bit          rst_ack;
    } ins_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] busc_in, busb_in, pc_in;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic [6:0]  op_in;
    logic        stall, wb_valid, misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, misalign_pc;

    stage_ma_lsu_if mem_bus ();

    stage_ma_lsu dut (
        .clk(clk), .rst(rst), .busc_in(busc_in), .busb_in(busb_in), .pc_in(pc_in),
        .rd_in(rd_in), .funct3_in(funct3_in), .op_in(op_in), .stall(stall),
        .mem(mem_bus), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign(misalign), .misalign_pc(misalign_pc)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int kind_of(input ins_t i);
        logic [1:0] a;
        a = i.busc[1:0];
        if (i.op == OP_LOAD || i.op == OP_STORE) begin
            if (i.op == OP_LOAD && !(i.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return K_NONE;
            if (i.op == OP_STORE && !(i.f3 inside {3'd0, 3'd1, 3'd2})) return K_NONE;
            if ((i.f3[1:0] == 2'd1 && (a % 2) != 0) || (i.f3[1:0] == 2'd2 && a != 0)) return K_MIS;
            return (i.op == OP_LOAD) ? K_LD : K_ST;
        end
        if (i.op inside {OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR}) return K_WR;
        return K_NONE;
    endfunction

    function automatic logic [31:0] exp_load(input ins_t i, input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * i.busc[1:0]);
        case (i.f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: v = rdata;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] exp_wdata(input ins_t i);
        if (i.f3 == 3'd0) return i.busb[7:0] * 32'h0101_0101;
        if (i.f3 == 3'd1) return i.busb[15:0] * 32'h0001_0001;
        return i.busb;
    endfunction

    function automatic logic [31:0] exp_be(input ins_t i);
        int nbytes;
        nbytes = 1 << i.f3[1:0];
        return ((1 << nbytes) - 1) << i.busc[1:0];
    endfunction

    function automatic ins_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] busc,
                                input logic [31:0] busb, input logic [31:0] pc, input logic [4:0] rd,
                                input int delay, input logic [31:0] rdata, input bit rst_ack);
        ins_t i;
        i.op = op; i.f3 = f3; i.busc = busc; i.busb = busb; i.pc = pc; i.rd = rd;
        i.delay = delay; i.rdata = rdata; i.rst_ack = rst_ack;
        return i;
    endfunction

    function automatic ins_t rnd_ins();
        logic [6:0] ops [10];
        ins_t i;
        ops = '{7'h00, OP_LOAD, OP_STORE, OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, 7'h73};
        i = mk(ops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
               5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom, ($urandom_range(0, 40) == 0));
        if ($urandom_range(0, 1) == 1) i.f3 = 3'($urandom_range(0, 2));
        return i;
    endfunction

    ins_t stim_q[$];
    ins_t cur, pend_ins;
    bit   pend, stall_exp, rst_now, ack;
    int   cnt;
    bit          e_wb, e_mis;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_mis_pc;

    initial begin
        stim_q.push_back(mk(OP_OP,    3'd0, 32'h0000_1234, 32'h0, 32'h10, 5'd5, 0, 32'h0, 1'b0));
        stim_q.push_back(mk(OP_LOAD,  3'd0, 32'h0000_0103, 32'h0, 32'h14, 5'd7, 2, 32'h80FF_0000, 1'b0));
        stim_q.push_back(mk(OP_STORE, 3'd1, 32'h0000_0202, 32'hDEAD_BEEF, 32'h18, 5'd0, 0, 32'h0, 1'b0));
        stim_q.push_back(mk(OP_LOAD,  3'd2, 32'h0000_0305, 32'h0, 32'h40, 5'd3, 0, 32'h0, 1'b0));
        stim_q.push_back(mk(OP_LOAD,  3'd5, 32'h0000_0010, 32'h0, 32'h44, 5'd9, 0, 32'h0000_9ABC, 1'b0));
        stim_q.push_back(mk(OP_STORE, 3'd2, 32'h0000_0014, 32'h1122_3344, 32'h48, 5'd0, 1, 32'h0, 1'b0));
        stim_q.push_back(mk(OP_LOAD,  3'd2, 32'h0000_0020, 32'h0, 32'h4C, 5'd4, 1, 32'h5555_AAAA, 1'b1));
        stim_q.push_back(mk(OP_IMM,   3'd0, 32'hCAFE_0001, 32'h0, 32'h50, 5'd0, 0, 32'h0, 1'b0));

        rst = 1'b1; op_in = 7'h00; funct3_in = 3'd0; busc_in = 32'h0; busb_in = 32'h0;
        pc_in = 32'h0; rd_in = 5'd0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
        cur = mk(7'h00, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 1'b0);
        pend = 1'b0; stall_exp = 1'b0; cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_stall", {31'd0, stall}, 32'd0);
        check_val("rst_req", {31'd0, mem_bus.mem_req}, 32'd0);
        check_val("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_val("rst_wb_data", wb_data, 32'd0);
        check_val("rst_misalign", {31'd0, misalign}, 32'd0);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (!stall_exp) begin
                cur = (stim_q.size() > 0) ? stim_q.pop_front() : rnd_ins();
                op_in = cur.op; funct3_in = cur.f3; busc_in = cur.busc; busb_in = cur.busb;
                pc_in = cur.pc; rd_in = cur.rd;
            end
            rst_now = 1'b0;
            ack = 1'b0;
            mem_bus.mem_rdata = $urandom;
            if (pend) begin
                if (cnt == 0) begin
                    ack = 1'b1;
                    mem_bus.mem_rdata = pend_ins.rdata;
                    rst_now = pend_ins.rst_ack;
                end
            end else begin
                ack = ($urandom_range(0, 3) == 0);
            end
            mem_bus.mem_ack = ack;
            rst = rst_now;
            #1;
            if (rst_now)   stall_exp = 1'b0;
            else if (pend) stall_exp = !ack;
            else           stall_exp = (kind_of(cur) == K_LD) || (kind_of(cur) == K_ST);
            check_val("stall", {31'd0, stall}, {31'd0, stall_exp});

            e_wb = 1'b0; e_mis = 1'b0;
            if (rst_now) begin
                pend = 1'b0; e_rd = 5'd0; e_data = 32'd0; e_mis_pc = 32'd0;
            end else if (pend) begin
                if (ack) begin
                    pend = 1'b0;
                    if (kind_of(pend_ins) == K_LD) begin
                        e_wb = 1'b1; e_rd = pend_ins.rd; e_data = exp_load(pend_ins, pend_ins.rdata);
                    end
                end else begin
                    cnt--;
                end
            end else begin
                case (kind_of(cur))
                    K_WR:  begin e_wb = 1'b1; e_rd = cur.rd; e_data = cur.busc; end
                    K_MIS: begin e_mis = 1'b1; e_mis_pc = cur.pc; end
                    K_LD, K_ST: begin pend = 1'b1; pend_ins = cur; cnt = cur.delay; end
                    default: ;
                endcase
            end

            @(posedge clk);
            #1;
            check_val("wb_valid", {31'd0, wb_valid}, {31'd0, e_wb});
            if (e_wb || rst_now) begin
                check_val("wb_rd", {27'd0, wb_rd}, {27'd0, e_rd});
                check_val("wb_data", wb_data, e_data);
            end
            check_val("misalign", {31'd0, misalign}, {31'd0, e_mis});
            if (e_mis || rst_now) check_val("misalign_pc", misalign_pc, e_mis_pc);
            check_val("mem_req", {31'd0, mem_bus.mem_req}, {31'd0, pend});
            if (pend) begin
                check_val("mem_addr", mem_bus.mem_addr, pend_ins.busc & 32'hFFFF_FFFC);
                check_val("mem_we", {31'd0, mem_bus.mem_we}, {31'd0, kind_of(pend_ins) == K_ST});
                if (kind_of(pend_ins) == K_ST) begin
                    check_val("mem_be", {28'd0, mem_bus.mem_be}, exp_be(pend_ins));
                    check_val("mem_wdata", mem_bus.mem_wdata, exp_wdata(pend_ins));
                end else begin
                    check_val("mem_be_ld", {28'd0, mem_bus.mem_be}, 32'd0);
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
